// File: rtl/tdc_pkg.sv
// tdc_pkg: shared state encoding, default widths and saturating increment for the TDC histogram
package tdc_pkg;
  localparam int TDC_DW = 20;
  localparam int TDC_BIN_BITS = 8;
  localparam int TDC_CNT_W = 16;
  typedef enum logic [1:0] {CLEAR = 2'd0, IDLE = 2'd1, ACQ = 2'd2, DUMP = 2'd3} state_e;
  function automatic logic [TDC_CNT_W-1:0] sat_inc(input logic [TDC_CNT_W-1:0] v);
    return (&v) ? v : v + 1'b1;
  endfunction
endpackage

// File: rtl/tdc_hist_ram.sv
// tdc_hist_ram: simple dual-port sync RAM (we/waddr/wdata write, re/raddr read, old data on collision)
module tdc_hist_ram #(
  parameter int AW = 8,
  parameter int W = 16
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [W-1:0]  wdata,
  input  logic          re,
  input  logic [AW-1:0] raddr,
  output logic [W-1:0]  rdata
);
  logic [W-1:0] mem [2**AW];
  logic [W-1:0] rdata_q;
  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
    if (re) rdata_q <= mem[raddr];
  end
  assign rdata = rdata_q;
endmodule

// File: rtl/tdc_hist.sv
// tdc_hist: bins valid TDC intervals (i_dval/i_data) into a RAM histogram under clr/arm/stop/dump commands and streams it out (o_bin/o_cnt/o_valid/i_ready/o_last) with hit/under/over counters
module tdc_hist
  import tdc_pkg::*;
#(
  parameter int          DW       = TDC_DW,
  parameter int          BIN_BITS = TDC_BIN_BITS,
  parameter int          SHIFT    = 4,
  parameter logic [DW-1:0] LO     = '0,
  parameter int          CNT_W    = TDC_CNT_W,
  parameter logic [31:0] MAX_HITS = '0
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                i_clr,
  input  logic                i_arm,
  input  logic                i_stop,
  input  logic                i_dump,
  input  logic                i_dval,
  input  logic [DW-1:0]       i_data,
  output logic [1:0]          o_state,
  output logic [31:0]         o_hits,
  output logic [CNT_W-1:0]    o_under,
  output logic [CNT_W-1:0]    o_over,
  output logic [BIN_BITS-1:0] o_bin,
  output logic [CNT_W-1:0]    o_cnt,
  output logic                o_valid,
  input  logic                i_ready,
  output logic                o_last
);
  typedef struct packed {
    state_e              st;
    logic [1:0]          drain;
    logic                clr_pend;
    logic [BIN_BITS-1:0] clr_addr;
    logic [31:0]         acc;
    logic [31:0]         hits;
    logic [CNT_W-1:0]    under;
    logic [CNT_W-1:0]    over;
    logic                v1;
    logic [BIN_BITS-1:0] idx1;
    logic                v2;
    logic [BIN_BITS-1:0] idx2;
    logic [CNT_W-1:0]    cnt2;
    logic                v3;
    logic [BIN_BITS-1:0] idx3;
    logic [CNT_W-1:0]    cnt3;
    logic [BIN_BITS:0]   rd_ptr;
    logic                pv;
    logic [BIN_BITS-1:0] pb;
    logic                ov;
    logic [BIN_BITS-1:0] bin;
    logic [CNT_W-1:0]    cnt;
  } regs_t;
  regs_t r_q, r_d;
  logic [DW:0] diff;
  logic [DW-1:0] sh;
  logic neg, ovr, accept, hit, xfer, load, issue;
  logic [CNT_W-1:0] base;
  logic ram_we, ram_re;
  logic [BIN_BITS-1:0] ram_waddr, ram_raddr;
  logic [CNT_W-1:0] ram_wdata, ram_rdata;
  assign diff = {1'b0, i_data} - {1'b0, LO};
  assign neg = diff[DW];
  assign sh = diff[DW-1:0] >> SHIFT;
  assign ovr = !neg && ((sh >> BIN_BITS) != '0);
  assign accept = r_q.st == ACQ && r_q.drain == 2'd0 && i_dval && !(MAX_HITS != 0 && r_q.acc >= MAX_HITS);
  assign hit = accept && !neg && !ovr;
  // v2 is the newest in-flight value, v3 the one written on the edge that also read S1's stale data
  assign base = (r_q.v2 && r_q.idx2 == r_q.idx1) ? r_q.cnt2 : (r_q.v3 && r_q.idx3 == r_q.idx1) ? r_q.cnt3 : ram_rdata;
  assign xfer = r_q.ov && i_ready;
  assign load = r_q.pv && (!r_q.ov || i_ready);
  assign issue = !r_q.rd_ptr[BIN_BITS] && (!r_q.pv || load);
  always_comb begin
    r_d = r_q;
    ram_we = r_q.v2;
    ram_waddr = r_q.idx2;
    ram_wdata = r_q.cnt2;
    ram_re = hit;
    ram_raddr = sh[BIN_BITS-1:0];
    r_d.v1 = hit;
    r_d.idx1 = sh[BIN_BITS-1:0];
    r_d.v2 = r_q.v1;
    r_d.idx2 = r_q.idx1;
    r_d.cnt2 = sat_inc(base);
    r_d.v3 = r_q.v2;
    r_d.idx3 = r_q.idx2;
    r_d.cnt3 = r_q.cnt2;
    r_d.hits = r_q.hits + 32'(r_q.v2);
    r_d.acc = r_q.acc + 32'(hit);
    r_d.under = (accept && neg) ? sat_inc(r_q.under) : r_q.under;
    r_d.over = (accept && ovr) ? sat_inc(r_q.over) : r_q.over;
    case (r_q.st)
      CLEAR: begin
        ram_we = 1'b1;
        ram_waddr = r_q.clr_addr;
        ram_wdata = '0;
        r_d.clr_addr = r_q.clr_addr + 1'b1;
        r_d.hits = '0;
        r_d.acc = '0;
        r_d.under = '0;
        r_d.over = '0;
        r_d.clr_pend = 1'b0;
        r_d.st = (&r_q.clr_addr) ? IDLE : CLEAR;
      end
      IDLE: begin
        r_d.rd_ptr = '0;
        r_d.pv = 1'b0;
        r_d.st = i_clr ? CLEAR : i_arm ? ACQ : i_dump ? DUMP : IDLE;
      end
      ACQ: begin
        if (r_q.drain != 2'd0) begin
          r_d.drain = r_q.drain - 1'b1;
          r_d.clr_pend = r_q.clr_pend || i_clr;
          if (r_q.drain == 2'd1) r_d.st = r_d.clr_pend ? CLEAR : IDLE;
        end else if (i_clr || i_stop || (MAX_HITS != 0 && r_d.acc >= MAX_HITS)) begin
          r_d.drain = 2'd2;
          r_d.clr_pend = i_clr;
        end
      end
      DUMP: begin
        r_d.clr_pend = r_q.clr_pend || i_clr;
        if (issue) begin
          ram_re = 1'b1;
          ram_raddr = r_q.rd_ptr[BIN_BITS-1:0];
          r_d.rd_ptr = r_q.rd_ptr + 1'b1;
          r_d.pb = r_q.rd_ptr[BIN_BITS-1:0];
        end
        r_d.pv = issue || (r_q.pv && !load);
        r_d.ov = load || (r_q.ov && !xfer);
        if (load) begin
          r_d.bin = r_q.pb;
          r_d.cnt = ram_rdata;
        end
        if (r_d.clr_pend && (!r_q.ov || xfer)) begin
          r_d.st = CLEAR;
          r_d.ov = 1'b0;
          r_d.pv = 1'b0;
        end else if (xfer && &r_q.bin) begin
          r_d.st = IDLE;
          r_d.ov = 1'b0;
        end
      end
    endcase
  end
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) r_q <= '0;
    else r_q <= r_d;
  end
  tdc_hist_ram #(.AW(BIN_BITS), .W(CNT_W)) u_ram (
    .clk(clk),
    .we(ram_we),
    .waddr(ram_waddr),
    .wdata(ram_wdata),
    .re(ram_re),
    .raddr(ram_raddr),
    .rdata(ram_rdata)
  );
  assign o_state = r_q.st;
  assign o_hits = r_q.hits;
  assign o_under = r_q.under;
  assign o_over = r_q.over;
  assign o_bin = r_q.bin;
  assign o_cnt = r_q.cnt;
  assign o_valid = r_q.ov;
  assign o_last = r_q.ov && (&r_q.bin);
endmodule

// File: tb/tb_tdc_hist.sv
// tb_tdc_hist: directed self-checking bench for tdc_hist (default instance and LO=0x100/MAX_HITS=100 instance)
module tb_tdc_hist;
  logic clk = 0, rst = 0;
  logic i_clr = 0, i_arm = 0, i_stop = 0, i_dump = 0, i_dval = 0, i_ready = 1;
  logic [19:0] i_data = '0;
  logic [1:0] st0, st1;
  logic [31:0] hits0, hits1;
  logic [15:0] under0, under1, over0, over1, cnt0, cnt1;
  logic [7:0] bin0, bin1;
  logic valid0, valid1, last0, last1;
  int n_chk = 0, errs = 0;
  int exp_h [256];
  int got [256];
  always #5 clk = ~clk;
  tdc_hist u0 (
    .clk(clk), .rst(rst), .i_clr(i_clr), .i_arm(i_arm), .i_stop(i_stop), .i_dump(i_dump),
    .i_dval(i_dval), .i_data(i_data), .o_state(st0), .o_hits(hits0), .o_under(under0),
    .o_over(over0), .o_bin(bin0), .o_cnt(cnt0), .o_valid(valid0), .i_ready(i_ready), .o_last(last0)
  );
  tdc_hist #(.LO(20'h00100), .MAX_HITS(32'd100)) u1 (
    .clk(clk), .rst(rst), .i_clr(i_clr), .i_arm(i_arm), .i_stop(i_stop), .i_dump(i_dump),
    .i_dval(i_dval), .i_data(i_data), .o_state(st1), .o_hits(hits1), .o_under(under1),
    .o_over(over1), .o_bin(bin1), .o_cnt(cnt1), .o_valid(valid1), .i_ready(i_ready), .o_last(last1)
  );
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask
  task automatic tick;
    @(posedge clk);
    #1;
  endtask
  task automatic hit(input logic [19:0] d);
    i_data = d;
    i_dval = 1;
    tick;
    i_dval = 0;
  endtask
  task automatic clear_and_wait;
    int n;
    i_clr = 1;
    tick;
    i_clr = 0;
    n = 0;
    while (st0 !== 2'd1 && n < 600) begin
      tick;
      n++;
    end
    chk("clear_to_idle", st0, 1);
    chk("clear_hits", hits0, 0);
    chk("clear_under", under1, 0);
  endtask
  task automatic stop_acq;
    i_stop = 1;
    tick;
    i_stop = 0;
    chk("drain_reported_acq", st0, 2);
    tick;
    tick;
    chk("drain_to_idle", st0, 1);
  endtask
  task automatic do_dump(input bit sel, input bit rnd, input string tag);
    int k, cyc;
    logic v, l, stall;
    logic [7:0] b, pb;
    logic [15:0] c, pc;
    k = 0;
    cyc = 0;
    stall = 0;
    pb = '0;
    pc = '0;
    i_dump = 1;
    tick;
    i_dump = 0;
    while (k < 256 && cyc < 3000) begin
      i_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      v = sel ? valid1 : valid0;
      b = sel ? bin1 : bin0;
      c = sel ? cnt1 : cnt0;
      l = sel ? last1 : last0;
      if (stall) begin
        chk({tag, "_stall_valid"}, v, 1);
        chk({tag, "_stall_bin"}, b, pb);
        chk({tag, "_stall_cnt"}, c, pc);
      end
      if (v && i_ready) begin
        got[k] = c;
        chk({tag, "_bin_order"}, b, k);
        chk({tag, "_last"}, l, k == 255);
        k++;
      end
      stall = v && !i_ready;
      pb = b;
      pc = c;
      tick;
      cyc++;
    end
    i_ready = 1;
    chk({tag, "_words"}, k, 256);
    chk({tag, "_end_idle"}, sel ? st1 : st0, 1);
    for (int i = 0; i < 256 && i < k; i++) chk({tag, "_cnt"}, got[i], exp_h[i]);
  endtask
  initial begin
    int n;
    repeat (3) tick;
    chk("rst_state", st0, 0);
    chk("rst_valid", valid0, 0);
    chk("rst_hits", hits0, 0);
    chk("rst_under", under0, 0);
    chk("rst_over", over0, 0);
    chk("rst_bin", bin0, 0);
    chk("rst_cnt", cnt0, 0);
    chk("rst_last", last0, 0);
    rst = 1;
    n = 0;
    while (st0 === 2'd0 && n < 400) begin
      tick;
      n++;
    end
    chk("clear_len", n, 256);
    chk("post_clear_idle", st0, 1);
    foreach (exp_h[i]) exp_h[i] = 0;
    do_dump(0, 0, "dump_zero");
    i_arm = 1;
    tick;
    i_arm = 0;
    chk("armed", st0, 2);
    repeat (10) begin
      hit(20'h007F0);
      tick;
      tick;
    end
    stop_acq;
    chk("single_hits", hits0, 10);
    exp_h[8'h7F] = 10;
    do_dump(0, 0, "dump_7f");
    chk("hits_kept_after_dump", hits0, 10);
    clear_and_wait;
    i_arm = 1;
    tick;
    i_arm = 0;
    repeat (20) begin
      hit(20'h00050);
      hit(20'h00060);
    end
    stop_acq;
    chk("fwd_hits", hits0, 40);
    foreach (exp_h[i]) exp_h[i] = 0;
    exp_h[5] = 20;
    exp_h[6] = 20;
    do_dump(0, 0, "dump_fwd");
    do_dump(0, 1, "dump_fwd_rnd");
    clear_and_wait;
    i_arm = 1;
    tick;
    i_arm = 0;
    hit(20'h000FF);
    tick;
    hit(20'h00100);
    tick;
    hit(20'h010FF);
    tick;
    hit(20'h01100);
    tick;
    stop_acq;
    chk("edge_under", under1, 1);
    chk("edge_over", over1, 1);
    chk("edge_hits", hits1, 2);
    chk("edge_lo0_hits", hits0, 2);
    chk("edge_lo0_over", over0, 2);
    foreach (exp_h[i]) exp_h[i] = 0;
    exp_h[0] = 1;
    exp_h[255] = 1;
    do_dump(1, 0, "dump_edge");
    clear_and_wait;
    i_arm = 1;
    tick;
    i_arm = 0;
    i_data = 20'h00100;
    i_dval = 1;
    repeat (150) tick;
    i_dval = 0;
    chk("max_state_idle", st1, 1);
    chk("max_hits", hits1, 100);
    chk("max_unlimited_acq", st0, 2);
    stop_acq;
    chk("unlimited_hits", hits0, 150);
    chk("max_hits_hold", hits1, 100);
    i_dump = 1;
    tick;
    i_dump = 0;
    repeat (10) tick;
    chk("mid_dump_valid", valid0, 1);
    chk("mid_dump_state", st0, 3);
    rst = 0;
    #1;
    chk("rst_mid_valid", valid0, 0);
    chk("rst_mid_state", st0, 0);
    chk("rst_mid_valid1", valid1, 0);
    chk("rst_mid_hits", hits0, 0);
    tick;
    rst = 1;
    tick;
    chk("rst_mid_clear", st0, 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, errs);
    $finish;
  end
endmodule
